// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access stage.
// Provides the access-size codes, the controller state encoding, the default
// bus timeout, and helpers for alignment checking and store lane steering.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Reserved size behaves as a word everywhere.
  function automatic logic misaligned(size_t sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(size_t sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(size_t sz, logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Request/acknowledge memory bus between the access unit (master) and the
// data memory (slave).
//   bus_req   : request, held until acknowledged or timed out
//   bus_we    : 1 = write
//   bus_addr  : word-aligned byte address
//   bus_be    : little-endian byte enables
//   bus_wdata : store data replicated into the addressed lanes
//   bus_rdata : read data, valid with bus_ack
//   bus_ack   : single-cycle completion strobe
interface dmem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/dmem_access_unit_load_extend.sv
// Load lane select and extension.
//   rdata_raw   : full bus word
//   addr_lo     : low two address bits of the access
//   size        : access size code (reserved treated as word)
//   ld_unsigned : 1 = zero-extend, 0 = sign-extend
//   data        : extended 32-bit load result
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_raw,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_sel = rdata_raw[{addr_lo[1], 4'b0000} +: 16];
    data     = rdata_raw;
    case (size_t'(size))
      SZ_BYTE: data = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
      default: data = rdata_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage downstream of the ALU.
// Issues byte/half/word loads and stores on a request/acknowledge bus with
// lane steering, load extension, alignment checking and a bus timeout, and
// stalls the core until the access retires in a one-cycle DONE state.
//   CLK, Reset          : clock, asynchronous active-low reset
//   addr, wdata         : effective address and right-aligned store data
//   mem_rd, mem_wr      : load / store request (store wins)
//   size, ld_unsigned   : access size and load extension mode
//   bus                 : memory bus (master side)
//   rdata               : extended load result, valid in DONE
//   stall               : combinational core hold
//   misalign_err        : misaligned access, high in DONE
//   bus_err             : timed-out access, high in DONE
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          size,
  input  logic                ld_unsigned,
  dmem_access_unit_if.master  bus,
  output logic [31:0]         rdata,
  output logic                stall,
  output logic                misalign_err,
  output logic                bus_err
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  size_t            size_q;
  logic             uns_q;
  logic [1:0]       lo_q;
  logic [31:0]      ld_data;

  load_extend u_load_extend (
    .rdata_raw  (bus.bus_rdata),
    .addr_lo    (lo_q),
    .size       (size_q),
    .ld_unsigned(uns_q),
    .data       (ld_data)
  );

  always_comb begin
    stall = (state == REQ) || ((state == IDLE) && (mem_rd || mem_wr));
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      size_q        <= SZ_BYTE;
      uns_q         <= 1'b0;
      lo_q          <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      rdata         <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_rd || mem_wr) begin
            if (misaligned(size_t'(size), addr[1:0])) begin
              misalign_err <= 1'b1;
              rdata        <= '0;
              state        <= DONE;
            end else begin
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_we    <= mem_wr;
              bus.bus_be    <= lane_be(size_t'(size), addr[1:0]);
              bus.bus_wdata <= lane_wdata(size_t'(size), wdata);
              bus.bus_req   <= 1'b1;
              size_q        <= size_t'(size);
              uns_q         <= ld_unsigned;
              lo_q          <= addr[1:0];
              cnt           <= '0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          // Acknowledge is tested first so it wins over a coincident timeout.
          if (bus.bus_ack) begin
            rdata       <= bus.bus_we ? '0 : ld_data;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus_err     <= 1'b1;
            rdata       <= '0;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          misalign_err <= 1'b0;
          bus_err      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;
  import dmem_pkg::*;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  size = '0;
  logic        ld_unsigned = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;
  logic        bus_err;

  dmem_access_unit_if bif ();

  dmem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .addr        (addr),
    .wdata       (wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .bus         (bif),
    .rdata       (rdata),
    .stall       (stall),
    .misalign_err(misalign_err),
    .bus_err     (bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
    int          stalls;
    int          reqs;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  int nvec = 0;
  int nerr = 0;

  int          ack_delay = -1;
  logic [31:0] rword = '0;
  bit          force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: lanes and extension from byte counts and shifts.
  function automatic void model(input logic [31:0] a, input logic [31:0] wd,
                                input logic wr, input logic [1:0] sz, input logic uns,
                                input int dly, input logic [31:0] rw,
                                output bus_exp_t b, output done_exp_t d, output bit on_bus);
    int n;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    mask = (64'd1 << (8 * n)) - 64'd1;
    b.we = wr; b.baddr = a & ~32'd3; b.be = '0; b.bwdata = '0;
    if ((off % n) != 0) begin
      on_bus = 0;
      d.rdata = '0; d.mis = 1'b1; d.berr = 1'b0; d.stalls = 1; d.reqs = 0;
      return;
    end
    on_bus = 1;
    b.be = 4'(((1 << n) - 1) << off);
    for (int k = 0; k < 4; k++) b.bwdata[8*k +: 8] = 8'(wd >> (8 * (k % n)));
    d.mis = 1'b0;
    if (dly >= 0 && dly < TO) begin
      d.reqs = dly + 1; d.stalls = dly + 2; d.berr = 1'b0;
      if (wr) d.rdata = '0;
      else begin
        v = ({32'd0, rw} >> (8 * off)) & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        d.rdata = v[31:0];
      end
    end else begin
      d.reqs = TO; d.stalls = TO + 1; d.berr = 1'b1; d.rdata = '0;
    end
  endfunction

  // Memory responder: checks request fields and acknowledges after ack_delay.
  int       rc = 0;
  bus_exp_t cur;
  initial begin
    bif.bus_ack = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge CLK);
      if (bif.bus_req === 1'b1) begin
        if (rc == 0) begin
          if (bus_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_bus_req: got 1, expected 0");
            cur = '{1'b0, 32'd0, 4'd0, 32'd0};
          end else cur = bus_q.pop_front();
        end
        chk("bus_we", 32'(bif.bus_we), 32'(cur.we));
        chk("bus_addr", bif.bus_addr, cur.baddr);
        chk("bus_be", 32'(bif.bus_be), 32'(cur.be));
        if (cur.we) chk("bus_wdata", bif.bus_wdata, cur.bwdata);
        bif.bus_ack = (ack_delay == rc);
        bif.bus_rdata = bif.bus_ack ? rword : $urandom;
        rc++;
      end else begin
        rc = 0;
        bif.bus_ack = force_ack;
        bif.bus_rdata = force_ack ? 32'hA5A5_A5A5 : 32'h0;
      end
    end
  end

  // Completion monitor: DONE is the first stall-low sample after stall-high.
  int mon_sc = 0;
  int mon_rq = 0;
  bit mon_prev = 0;
  bit mon_post = 0;
  done_exp_t dexp;
  initial begin
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        mon_sc = 0; mon_rq = 0; mon_prev = 0; mon_post = 0;
      end else begin
        if (mon_post) begin
          chk("misalign_clr", 32'(misalign_err), 32'd0);
          chk("bus_err_clr", 32'(bus_err), 32'd0);
          mon_post = 0;
        end
        if (bif.bus_req) mon_rq++;
        if (stall) mon_sc++;
        else if (mon_prev) begin
          if (done_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_done: got 1, expected 0");
          end else begin
            dexp = done_q.pop_front();
            chk("rdata", rdata, dexp.rdata);
            chk("misalign_err", 32'(misalign_err), 32'(dexp.mis));
            chk("bus_err", 32'(bus_err), 32'(dexp.berr));
            chk("stall_cycles", 32'(mon_sc), 32'(dexp.stalls));
            chk("req_cycles", 32'(mon_rq), 32'(dexp.reqs));
          end
          mon_sc = 0; mon_rq = 0; mon_post = 1;
        end
        mon_prev = stall;
      end
    end
  end

  // Called at posedge+1 with the unit in IDLE; returns at posedge+1 after DONE.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic uns,
                       input int dly, input logic [31:0] rw);
    bus_exp_t  b;
    done_exp_t d;
    bit        on_bus;
    bit        seen;
    model(a, wd, wr, sz, uns, dly, rw, b, d, on_bus);
    if (on_bus) bus_q.push_back(b);
    done_q.push_back(d);
    ack_delay = on_bus ? dly : -1;
    rword = rw;
    addr = a; wdata = wd; mem_rd = rd; mem_wr = wr; size = sz; ld_unsigned = uns;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (!stall) seen = 1;
    end
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL access_completion: got no DONE, expected DONE within 100 cycles");
    end
    @(posedge CLK); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int r;
    int dly;
    logic [31:0] a;
    logic [1:0]  sz;
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_bus_we", 32'(bif.bus_we), 32'd0);
    chk("rst_bus_be", 32'(bif.bus_be), 32'd0);
    chk("rst_bus_addr", bif.bus_addr, 32'd0);
    chk("rst_bus_wdata", bif.bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flags", {30'd0, misalign_err, bus_err}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;

    // Directed cases
    issue(32'h0000_1004, 32'h0, 1, 0, 2'b10, 0, 0, 32'hDEAD_BEEF);
    issue(32'h0000_2003, 32'h0, 1, 0, 2'b00, 0, 0, 32'h8012_3456);
    issue(32'h0000_2003, 32'h0, 1, 0, 2'b00, 1, 1, 32'h8012_3456);
    issue(32'h0000_3002, 32'h0000_1234, 0, 1, 2'b01, 0, 2, 32'h0);
    issue(32'h0000_4006, 32'h0, 1, 0, 2'b10, 0, 0, 32'h1111_1111);
    issue(32'h0000_5000, 32'h0, 1, 0, 2'b10, 0, -1, 32'h0);
    issue(32'h0000_5004, 32'h0, 1, 0, 2'b01, 1, TO - 1, 32'hF00D_8001);
    issue(32'h0000_6002, 32'hCAFE_F00D, 1, 1, 2'b11, 0, 0, 32'h0);

    // Randomized accesses
    for (int t = 0; t < 150; t++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        case (sz)
          2'b00:   a[1:0] = 2'($urandom_range(0, 3));
          2'b01:   a[0] = 1'b0;
          default: a[1:0] = 2'b00;
        endcase
      end
      r = $urandom_range(0, 9);
      dly = (r < 6) ? (r % 4) : (r == 6) ? TO - 1 : (r == 7) ? TO : -1;
      r = $urandom_range(0, 2);
      issue(a, $urandom, (r != 1), (r != 0), sz, 1'($urandom_range(0, 1)), dly, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    // Reset in the third REQ cycle
    bus_q.push_back('{1'b0, 32'h0000_2000, 4'b1111, 32'h0});
    ack_delay = -1;
    addr = 32'h0000_2000; size = 2'b10; mem_rd = 1'b1; mem_wr = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    Reset = 1'b0; mem_rd = 1'b0;
    #1;
    chk("rst_mid_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge CLK);
    chk("rst_mid_bus_be", 32'(bif.bus_be), 32'd0);
    chk("rst_mid_bus_addr", bif.bus_addr, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_flags", {30'd0, misalign_err, bus_err}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1;
    force_ack = 1'b1;
    @(posedge CLK); #1;
    force_ack = 1'b0;
    @(negedge CLK);
    chk("late_ack_bus_req", 32'(bif.bus_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_rdata", rdata, 32'd0);
    @(posedge CLK); #1;
    issue(32'h0000_7001, 32'h0, 1, 0, 2'b00, 0, 1, 32'h0000_FF00);

    repeat (3) @(posedge CLK);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory access stage directly downstream of the ALU.
- Takes the ALU Result as the effective address and the register-file ReadData2 as store data.
- Performs byte, half-word and word loads and stores over a request/acknowledge memory bus, with lane steering, load extension, alignment checking and a bus timeout.
- Holds the single-cycle core with `stall` until the access completes, then presents load data to write-back for exactly one cycle.

Parameters:
- TIMEOUT, 16: maximum REQ-state cycles waiting for bus_ack before the access is aborted; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- addr  in  32  effective byte address (ALU Result).
- wdata  in  32  store data (ReadData2), right-aligned.
- mem_rd  in  1  load request for the current instruction.
- mem_wr  in  1  store request for the current instruction; wins if mem_rd is also high.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ld_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- bus_req  out  1  memory request, held until acknowledged or timed out.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables, little-endian (lane k = bits 8k+7:8k).
- bus_wdata  out  32  store data replicated into the addressed lanes.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  single-cycle completion strobe.
- rdata  out  32  extended load result, valid in DONE.
- stall  out  1  combinational; freezes PC and register write while high.
- misalign_err  out  1  registered; high in DONE for a misaligned access.
- bus_err  out  1  registered; high in DONE for a timed-out access.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-access):
  - state = IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, misalign_err, bus_err and the counter all 0.
  - An access in flight is abandoned; bus_req drops without waiting for bus_ack.
- States: IDLE, REQ, DONE.
- IDLE:
  - If mem_rd or mem_wr is high: stall = 1.
  - Aligned access: latch bus_addr, bus_we, bus_be and bus_wdata; capture size and ld_unsigned; clear the counter; go to REQ.
  - Misaligned access (half with addr[0] = 1, or word/reserved with addr[1:0] != 0): no bus cycle; set misalign_err; rdata = 0; go to DONE.
- REQ:
  - bus_req = 1 and stall = 1; bus outputs are stable for the whole state.
  - bus_ack high: capture and extend the load data into rdata (stores leave rdata = 0); go to DONE.
  - Otherwise, when counter = TIMEOUT-1: set bus_err; rdata = 0; go to DONE. Otherwise increment the counter.
  - If bus_ack and timeout occur in the same cycle, bus_ack wins.
- DONE:
  - bus_req = 0 and stall = 0 for exactly one cycle; the instruction retires on this edge.
  - Go to IDLE; clear misalign_err and bus_err on that transition.
  - mem_rd/mem_wr are ignored in DONE, so an access is never reissued.
- Latency:
  - An access acknowledged in the first REQ cycle stalls 2 cycles, then DONE.
  - A misaligned access stalls 1 cycle.
- Lane rules:
  - Byte: be = 1 << addr[1:0]; wdata[7:0] replicated into all 4 lanes.
  - Half: be = 0011 when addr[1] = 0, else 1100; wdata[15:0] replicated into both halves.
  - Word: be = 1111.
- Load extension: select the addressed byte or half-word from bus_rdata, then sign- or zero-extend to 32 bits per ld_unsigned.
- No outstanding-request queueing; at most one access in flight.

Decomposition:
- Package dmem_pkg:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding IDLE/REQ/DONE;
  - default TIMEOUT.
- Sub-module load_extend: combinational lane select plus sign/zero extension (inputs rdata_raw, addr_lo[1:0], size, ld_unsigned).

Test Plan:
- Word load, addr = 0x0000_1004, bus_rdata = 0xDEAD_BEEF, ack in first REQ cycle -> bus_addr = 0x1004, be = 1111; stall high for 2 cycles; DONE rdata = 0xDEAD_BEEF.
- Signed byte load, addr = 0x...03, bus_rdata = 0x80xx_xxxx -> be = 1000; rdata = 0xFFFF_FF80. Repeat with ld_unsigned = 1 -> rdata = 0x0000_0080.
- Half store, addr = 0x...02, wdata = 0x0000_1234 -> bus_we = 1, be = 1100, bus_wdata = 0x1234_1234; stall drops after ack.
- Word load, addr = 0x...06 -> bus_req never asserted; 1 stall cycle; DONE with misalign_err = 1, rdata = 0.
- No ack, TIMEOUT = 16 -> bus_req high 16 cycles; DONE with bus_err = 1; IDLE next cycle with both error flags 0.
- Reset asserted in the 3rd REQ cycle -> bus_req = 0 immediately; after release state = IDLE, all outputs 0; a late bus_ack is ignored.
